// File: rtl/dac_spi_seq_if.sv
// Command port of the DAC SPI sequencer: one frame plus its target channel,
// transferred on a valid/ready handshake.
interface dac_spi_seq_if #(
    parameter int DWIDTH = 24,
    parameter int CHW    = 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DWIDTH-1:0] cmd_data;
    logic [CHW-1:0]    cmd_ch;

    // Sender side (command decoder / testbench)
    modport master (output cmd_valid, output cmd_data, output cmd_ch, input cmd_ready);
    // Receiver side (the sequencer)
    modport slave  (input cmd_valid, input cmd_data, input cmd_ch, output cmd_ready);
endinterface

// File: rtl/dac_spi_seq.sv
// Queued multi-channel SPI write engine for the board DACs.
// Frames arrive through a small FIFO and are shifted out MSB first on a shared
// SCLK/DIN pair, framed by one active-low SYNC line per DAC. After reset the
// engine waits for the init counter, sends one power-up frame per channel, and
// only then releases queued user traffic.
module dac_spi_seq #(
    parameter int                DWIDTH      = 24,
    parameter int                CHW         = 1,
    parameter int                CLKDIV      = 16,
    parameter int                GAP         = 32,
    parameter int                FDEPTH_LOG2 = 2,
    parameter logic [31:0]       WTIME1      = 32'd10000000,
    parameter logic [31:0]       WTIME2      = 32'd30000000,
    parameter logic [DWIDTH-1:0] INIT_FRAME  = DWIDTH'(24'h080000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dac_spi_seq_if.slave         cmd,
    output logic                 spi_sclk,
    output logic                 spi_data,
    output logic [(2**CHW)-1:0]  spi_sync,
    output logic                 busy,
    output logic                 init_done,
    output logic [FDEPTH_LOG2:0] fifo_count
);

    localparam int NCH   = 2 ** CHW;
    localparam int DEPTH = 2 ** FDEPTH_LOG2;
    localparam int CW    = FDEPTH_LOG2 + 1;
    localparam int DIVW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BITW  = $clog2(DWIDTH);
    localparam int GAPW  = $clog2(GAP + 1);
    localparam int FW    = CHW + DWIDTH;

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_LOAD      = 3'd2,
        S_SHIFT     = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [DIVW-1:0]        div_q, div_d;
    logic [BITW-1:0]        bit_q, bit_d;
    logic [GAPW-1:0]        gap_q, gap_d;
    logic [DWIDTH-1:0]      shreg_q, shreg_d;
    logic                   init_pend_q, init_pend_d;
    logic                   init_seq_q, init_seq_d;
    logic [CHW-1:0]         init_idx_q, init_idx_d;
    logic                   init_done_q, init_done_d;
    logic                   sclk_q, sclk_d;
    logic                   data_q, data_d;
    logic [NCH-1:0]         sync_q, sync_d;
    logic                   busy_q, busy_d;

    logic [FW-1:0]          mem_q [DEPTH];
    logic [FDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FDEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   launch_s;
    logic [DWIDTH-1:0]      launch_frame_s;
    logic [CHW-1:0]         launch_ch_s;
    logic [FW-1:0]          head_s;

    assign full_s        = (count_q == CW'(DEPTH));
    assign push_s        = cmd.cmd_valid & ~full_s;
    assign head_s        = mem_q[rd_ptr_q];
    assign cmd.cmd_ready = ~full_s;

    assign spi_sclk   = sclk_q;
    assign spi_data   = data_q;
    assign spi_sync   = sync_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
    assign fifo_count = count_q;

    // State register, counters, shifter, registered pin drivers and FIFO storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT_WAIT;
            cnt_q       <= 32'd0;
            div_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            shreg_q     <= '0;
            init_pend_q <= 1'b0;
            init_seq_q  <= 1'b0;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            sclk_q      <= 1'b1;
            data_q      <= 1'b0;
            sync_q      <= '1;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            shreg_q     <= shreg_d;
            init_pend_q <= init_pend_d;
            init_seq_q  <= init_seq_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            sclk_q      <= sclk_d;
            data_q      <= data_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= {cmd.cmd_ch, cmd.cmd_data};
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end

    // Next-state, bit timing, init sequencing and FIFO bookkeeping
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_d          = div_q;
        bit_d          = bit_q;
        gap_d          = gap_q;
        shreg_d        = shreg_q;
        init_pend_d    = init_pend_q;
        init_seq_d     = init_seq_q;
        init_idx_d     = init_idx_q;
        init_done_d    = init_done_q;
        sclk_d         = sclk_q;
        data_d         = data_q;
        sync_d         = sync_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        pop_s          = 1'b0;
        launch_s       = 1'b0;
        launch_frame_s = '0;
        launch_ch_s    = '0;

        // Free-running init counter, parked at WTIME2 once it gets there
        if (cnt_q == WTIME2) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == WTIME1) begin
                    init_pend_d = 1'b1;
                    init_seq_d  = 1'b1;
                    init_idx_d  = '0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_INIT_WAIT;
                end
            end
            S_IDLE: begin
                // Power-up frames go first and never touch the FIFO
                if (init_pend_q) begin
                    launch_s       = 1'b1;
                    launch_frame_s = INIT_FRAME;
                    launch_ch_s    = init_idx_q;
                    init_idx_d     = init_idx_q + CHW'(1);
                    if (init_idx_q == CHW'(NCH - 1)) begin
                        init_pend_d = 1'b0;
                    end else begin
                        init_pend_d = 1'b1;
                    end
                end else if (init_done_q) begin
                    if (count_q != '0) begin
                        launch_s       = 1'b1;
                        launch_frame_s = head_s[DWIDTH-1:0];
                        launch_ch_s    = head_s[FW-1:DWIDTH];
                        pop_s          = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (init_seq_q && (cnt_q == WTIME2)) begin
                    init_done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD, S_SHIFT: begin
                // The LOAD cycle is already the first SCLK-high cycle of bit 0
                state_d = S_SHIFT;
                if (div_q == DIVW'(CLKDIV - 1)) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == BITW'(DWIDTH - 1)) begin
                        sclk_d  = 1'b1;
                        data_d  = 1'b0;
                        sync_d  = '1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[DWIDTH-2:0], 1'b0};
                        data_d  = shreg_q[DWIDTH-2];
                        bit_d   = bit_q + BITW'(1);
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            S_GAP: begin
                // First GAP cycle is the one where SYNC deasserts; GAP quiet cycles follow
                if (gap_q == GAPW'(GAP)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAPW'(1);
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
                sclk_d  = 1'b1;
                data_d  = 1'b0;
                sync_d  = '1;
            end
        endcase

        // Frame launch: SYNC, first data bit and shifter are all loaded on the LOAD edge
        if (launch_s) begin
            state_d = S_LOAD;
            shreg_d = launch_frame_s;
            data_d  = launch_frame_s[DWIDTH-1];
            sclk_d  = 1'b1;
            sync_d  = ~(NCH'(1) << launch_ch_s);
            div_d   = '0;
            bit_d   = '0;
        end else begin
            shreg_d = shreg_d;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + FDEPTH_LOG2'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FDEPTH_LOG2'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_GAP) ||
                 (count_d != '0);
    end

endmodule

// File: tb/tb_dac_spi_seq.sv
// Self-checking bench for dac_spi_seq: a pin-level frame monitor turns the
// SYNC/SCLK/DIN waveform into frame records that are scored against a queue
// of frames the bench itself expects (power-up frames, then accepted pushes).
`timescale 1ns/1ps
module tb_dac_spi_seq;

    localparam int          DW     = 24;
    localparam int          CHW    = 1;
    localparam int          CD     = 2;
    localparam int          GP     = 4;
    localparam int          FL     = 2;
    localparam logic [31:0] W1     = 32'd10;
    localparam logic [31:0] W2     = 32'd400;
    localparam int          NCH    = 2;
    localparam int          DEPTH  = 4;
    localparam int          FLEN   = DW * 2 * CD;
    localparam int          PERIOD = FLEN + GP + 2;
    localparam logic [DW-1:0] INITF = 24'h080000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           spi_sclk, spi_data, busy, init_done;
    logic [NCH-1:0] spi_sync;
    logic [FL:0]    fifo_count;

    dac_spi_seq_if #(.DWIDTH(DW), .CHW(CHW)) cmd_if ();

    dac_spi_seq #(
        .DWIDTH(DW), .CHW(CHW), .CLKDIV(CD), .GAP(GP), .FDEPTH_LOG2(FL),
        .WTIME1(W1), .WTIME2(W2), .INIT_FRAME(INITF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
        .spi_sclk(spi_sclk), .spi_data(spi_data), .spi_sync(spi_sync),
        .busy(busy), .init_done(init_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
    } exp_t;

    typedef struct {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
        int             bits;
        int             len;
        int             start;
        int             first_fall;
    } cap_t;

    typedef struct {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
        int             exp_bits;
        int             exp_len;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    int   init_left = NCH;
    int   last_start = -1;
    bit   in_frame = 1'b0;
    logic prev_sclk = 1'b1;
    cap_t cur;
    exp_t expq[$];
    cap_t capq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: wait for the falling edge, then monitor pins and check occupancy
    task automatic step();
        @(negedge clk);
        cyc++;
        chk("sync_at_most_one_low", ($countones(~spi_sync) <= 1), 1'b1);
        if (!in_frame) begin
            if (spi_sync != '1) begin
                in_frame = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    if (!spi_sync[i]) cur.ch = CHW'(i);
                end
                cur.data = '0; cur.bits = 0; cur.len = 1;
                cur.start = cyc; cur.first_fall = -1;
                last_start = cyc;
                if (init_left > 0) init_left--;
                else model_cnt--;
            end
        end else begin
            if (spi_sync == '1) begin
                capq.push_back(cur);
                in_frame = 1'b0;
            end else begin
                cur.len++;
                if (prev_sclk && !spi_sclk) begin
                    cur.data = {cur.data[DW-2:0], spi_data};
                    cur.bits++;
                    if (cur.first_fall < 0) cur.first_fall = cyc;
                end
            end
        end
        prev_sclk = spi_sclk;
        chk("fifo_count_model", fifo_count, model_cnt);
        chk("cmd_ready_model", cmd_if.cmd_ready, (model_cnt < DEPTH));
        if (in_frame || model_cnt > 0) chk("busy_when_active", busy, 1'b1);
    endtask

    // Offer one frame for one cycle; acc tells whether it was taken
    task automatic offer(input logic [CHW-1:0] ch, input logic [DW-1:0] d, output bit acc);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = ch;
        cmd_if.cmd_data  = d;
        acc = cmd_if.cmd_ready;
        if (acc) begin
            expq.push_back('{ch, d});
            model_cnt++;
        end
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic push_hold(input logic [CHW-1:0] ch, input logic [DW-1:0] d);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 1000) begin
            offer(ch, d, acc);
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_timeout: got not-accepted, expected accepted within 1000 cycles");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    // Wait for the next captured frame and score it against the expected queue
    task automatic check_frame(input string name, output cap_t r);
        int   n;
        exp_t e;
        n = 0;
        while (capq.size() == 0 && n < 3000) begin
            step();
            n++;
        end
        if (capq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no frame, expected one within 3000 cycles", name);
            r = '{default: 0};
        end else begin
            r = capq.pop_front();
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_unexpected: got frame %0h, expected none", name, r.data);
            end else begin
                e = expq.pop_front();
                chk({name, "_ch"}, r.ch, e.ch);
                chk({name, "_data"}, r.data, e.data);
            end
            chk({name, "_bits"}, r.bits, DW);
            chk({name, "_len"}, r.len, FLEN);
        end
    endtask

    initial begin
        vec_t        vt[5];
        cap_t        r, rp;
        bit          acc;
        int          rel, t, done_cyc, n, accepted, rej_cyc, acc5_cyc;
        logic [DW-1:0] bd[5];

        vt[0] = '{1'b1, 24'h3F1234, DW, FLEN};
        vt[1] = '{1'b0, 24'hFFFFFF, DW, FLEN};
        vt[2] = '{1'b1, 24'h000001, DW, FLEN};
        vt[3] = '{1'b0, 24'h800000, DW, FLEN};
        vt[4] = '{1'b0, 24'hA5A5A5, DW, FLEN};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_ch    = '0;

        // Reset state
        repeat (3) step();
        chk("rst_sclk", spi_sclk, 1'b1);
        chk("rst_data", spi_data, 1'b0);
        chk("rst_sync", spi_sync, 2'b11);
        chk("rst_ready", cmd_if.cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_fifo_count", fifo_count, 3'd0);

        rst_n = 1'b1;
        rel = cyc;
        for (int c = 0; c < NCH; c++) expq.push_back('{CHW'(c), INITF});

        // Two user frames queued while the engine is still waiting
        step();
        offer(1'b1, 24'h111111, acc);
        chk("initwait_push0_acc", acc, 1'b1);
        offer(1'b0, 24'h222222, acc);
        chk("initwait_push1_acc", acc, 1'b1);
        chk("initwait_count", fifo_count, 3'd2);

        check_frame("init0", r);
        chk("init0_start_window", (r.start - rel >= W1) && (r.start - rel <= W1 + 3), 1'b1);
        check_frame("init1", rp);
        chk("init_period", rp.start - r.start, PERIOD);
        chk("init_done_still_low", init_done, 1'b0);

        n = 0;
        while (!init_done && n < 1000) begin
            step();
            n++;
        end
        done_cyc = cyc;
        chk("init_done_window", (done_cyc - rel >= W2) && (done_cyc - rel <= W2 + 2), 1'b1);

        check_frame("held0", r);
        chk("held0_after_init_done", r.start > done_cyc, 1'b1);
        check_frame("held1", rp);
        chk("held_period", rp.start - r.start, PERIOD);

        // Directed single frames: latency, bit order and MSB/LSB boundaries
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            t = cyc;
            offer(vt[i].ch, vt[i].data, acc);
            chk("vec_acc", acc, 1'b1);
            check_frame("vec", r);
            chk("vec_tbl_ch", r.ch, vt[i].ch);
            chk("vec_tbl_data", r.data, vt[i].data);
            chk("vec_tbl_bits", r.bits, vt[i].exp_bits);
            chk("vec_tbl_len", r.len, vt[i].exp_len);
            chk("vec_sync_latency", r.start - t, 2);
            chk("vec_first_fall", r.first_fall - t, 2 + CD);
        end

        // Back to back against a busy engine; fifth push must wait for a pop
        wait_idle();
        offer(1'b0, 24'hC0FFEE, acc);
        repeat (3) step();
        for (int i = 0; i < 5; i++) bd[i] = DW'($urandom);
        accepted = 0; rej_cyc = -1; acc5_cyc = -1; n = 0;
        while (accepted < 5 && n < 400) begin
            t = cyc;
            offer(CHW'(accepted & 1), bd[accepted], acc);
            if (acc) begin
                accepted++;
                if (accepted == 5) acc5_cyc = t;
            end else begin
                if (rej_cyc < 0) chk("ready_drop_at_4", fifo_count, 3'd4);
                rej_cyc = t;
            end
            n++;
        end
        chk("b2b_all_accepted", accepted, 5);
        chk("fifth_taken_at_pop", acc5_cyc, last_start);
        chk("full_reject_in_pop_cycle", rej_cyc, acc5_cyc - 1);
        check_frame("b2b_pre", rp);
        for (int i = 0; i < 5; i++) begin
            check_frame("b2b", r);
            chk("b2b_period", r.start - rp.start, PERIOD);
            rp = r;
        end

        // Randomised traffic scored against the expected queue
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 150)) step();
            push_hold(CHW'($urandom_range(0, 1)), DW'($urandom));
        end
        for (int i = 0; i < 10; i++) check_frame("rand", r);

        // Reset in the middle of a frame with another frame queued
        wait_idle();
        offer(1'b1, 24'h5A5A5A, acc);
        offer(1'b0, 24'h123456, acc);
        repeat (40) step();
        chk("midframe_active", (spi_sync != 2'b11), 1'b1);
        rst_n = 1'b0;
        model_cnt = 0;
        step();
        chk("mid_rst_sync", spi_sync, 2'b11);
        chk("mid_rst_sclk", spi_sclk, 1'b1);
        chk("mid_rst_data", spi_data, 1'b0);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_init_done", init_done, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        rel = cyc;
        capq.delete();
        expq.delete();
        in_frame = 1'b0;
        init_left = NCH;
        for (int c = 0; c < NCH; c++) expq.push_back('{CHW'(c), INITF});
        check_frame("reinit0", r);
        chk("reinit0_start_window", (r.start - rel >= W1) && (r.start - rel <= W1 + 3), 1'b1);
        check_frame("reinit1", rp);
        chk("reinit_period", rp.start - r.start, PERIOD);
        chk("no_stale_frames", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
